// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and status flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to build sticky overflow/underflow flags.
module sync_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int AFULL_LVL  = 6,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C =
    (ADDR_WIDTH+1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C =
    (ADDR_WIDTH+1)'(AEMPTY_LVL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  wr_acc, rd_acc;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign rdata        = rdata_q;
  assign rvalid       = rvalid_q;

  // A read frees a slot, so a full FIFO still takes a same-cycle write.
  assign rd_acc = ren && !empty;
  assign wr_acc = wen && (!full || rd_acc);

  always_comb begin
    mem_d    = mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (wr_acc) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + 1'b1;
    end
    if (rd_acc) begin
      rdata_d  = mem_q[rptr_q];
      rptr_d   = rptr_q + 1'b1;
      rvalid_d = 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q || (wen && !wr_acc);
    udf_d = udf_q || (ren && !rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised scoreboard bench for sync_fifo against a queue model.
// Flag checks follow SYNC_FIFO_ERR_FLAGS_EN when defined.
module tb_sync_fifo;

  localparam int DW    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int AEL   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wen = 1'b0;
  logic          ren = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          full, empty;
  logic          almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  sync_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AFULL_LVL (AFL),
    .AEMPTY_LVL(AEL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wen         (wen),
    .wdata       (wdata),
    .ren         (ren),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int model_q[$];
  int exp_q[$];
  int m_ovf = 0;
  int m_udf = 0;
  bit has_err;

  task automatic chk(input string name, input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    int n;
    n = model_q.size();
    chk({tag, " count"}, int'(count), n);
    chk({tag, " full"}, int'(full), int'(n == DEPTH));
    chk({tag, " empty"}, int'(empty), int'(n == 0));
    chk({tag, " afull"}, int'(almost_full), int'(n >= AFL));
    chk({tag, " aempty"}, int'(almost_empty), int'(n <= AEL));
    chk({tag, " ovf"}, int'(overflow), has_err ? m_ovf : 0);
    chk({tag, " udf"}, int'(underflow), has_err ? m_udf : 0);
  endtask

  task automatic step(input bit w, input bit r,
                      input int d, input string tag);
    bit rd_ok, wr_ok;
    @(negedge clk);
    wen   = w;
    ren   = r;
    wdata = DW'(d);
    rd_ok = r && model_q.size() > 0;
    wr_ok = w && (model_q.size() < DEPTH || rd_ok);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d % 16);
    if (w && !wr_ok) m_ovf = 1;
    if (r && !rd_ok) m_udf = 1;
    @(posedge clk);
    #1;
    chk_status(tag);
  endtask

  task automatic do_reset(input bit w, input bit r);
    @(negedge clk);
    rst   = 1'b1;
    wen   = w;
    ren   = r;
    wdata = 4'h9;
    model_q.delete();
    m_ovf = 0;
    m_udf = 0;
    @(posedge clk);
    #1;
    chk_status("reset");
    chk("reset rdata", int'(rdata), 0);
    chk("reset rvalid", int'(rvalid), 0);
    @(negedge clk);
    rst = 1'b0;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  // Output monitor: one expected word per accepted read, else rdata holds.
  int last_rd = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last_rd = 0;
      end else if (exp_q.size() > 0) begin
        last_rd = exp_q.pop_front();
        chk("rvalid pulse", int'(rvalid), 1);
        chk("rdata", int'(rdata), last_rd);
      end else begin
        chk("rvalid idle", int'(rvalid), 0);
        chk("rdata hold", int'(rdata), last_rd);
      end
    end
  end

  initial begin
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    has_err = 1'b1;
`else
    has_err = 1'b0;
`endif
    do_reset(1'b0, 1'b0);

    for (int i = 1; i <= 3; i++) step(1, 0, i, "wr123");
    for (int i = 0; i < 3; i++) step(0, 1, 0, "rd123");
    step(0, 0, 0, "idle");

    for (int i = 0; i < 8; i++) step(1, 0, i, "fill");
    step(1, 0, 15, "ovf");
    step(1, 1, 10, "full rw");
    for (int i = 0; i < 8; i++) step(0, 1, 0, "drain");
    step(1, 1, 5, "empty rw");
    step(0, 1, 0, "rd5");
    step(0, 0, 0, "idle2");

    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, i + 3, "wrap w");
      if (i >= 2) step(0, 1, 0, "wrap r");
    end
    while (model_q.size() > 0) step(0, 1, 0, "wrap drain");

    for (int i = 0; i < 400; i++) begin
      int wb, rb;
      wb = (i % 100 < 50) ? 70 : 30;
      rb = 100 - wb;
      step(($urandom % 100) < wb, ($urandom % 100) < rb,
           int'($urandom % 16), "rand");
    end

    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1, 0, i + 8, "pre rst");
    do_reset(1'b1, 1'b0);
    step(1, 0, 12, "post rst w");
    step(0, 1, 0, "post rst r");
    step(0, 0, 0, "tail");
    step(0, 0, 0, "tail");

    chk("scoreboard empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
